prog_loader: RTL
================

Name: prog_loader

Overview:
- Program writer for the 8-bit stored-program machine's 256x8 SRAM.
- Accepts a byte stream on a valid/ready port and writes it into SRAM starting at address 0, driving the SRAM's address/data/write port.
- Holds the processor in reset while loading and releases it when the image is complete.
- Sits between a host/UART byte source and the SRAM write port. A muxing wrapper gives the loader the SRAM port whenever cpu_rst_n is low.

Parameters:
- word_size, 8, data and address width; SRAM depth is 2**word_size.
- cnt_size, 9, width of the internal length and remaining counter; must be word_size+1.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle request to begin a load; ignored in LEN, LOAD, CHK.
- in_valid  input  1  source holds a byte on in_data.
- in_data  input  word_size  stream byte.
- in_ready  output  1  loader accepts a byte this cycle; transfer occurs when in_valid and in_ready are both high at a rising edge.
- mem_addr  output  word_size  SRAM address, equal to the write pointer.
- mem_data  output  word_size  SRAM write data, equal to in_data.
- mem_write  output  1  SRAM write strobe; the SRAM captures data on the same rising edge as the handshake.
- cpu_rst_n  output  1  registered, active-low processor reset.
- done  output  1  high while in RUN.
- err  output  1  high while in ERR; only exists with the checksum feature, otherwise tied 0.

Behaviour:
- Reset values: state IDLE, write pointer 0, remaining 0, cpu_rst_n 0, in_ready 0, mem_write 0, done 0, err 0.
- State register: IDLE, LEN, LOAD, CHK, RUN, ERR.
- IDLE:
  - in_ready=0.
  - start -> LEN; write pointer cleared to 0.
- LEN:
  - in_ready=1.
  - On handshake, remaining = (in_data==0) ? 256 : in_data, zero-extended to cnt_size. Length byte 0 therefore means a full 256-byte image.
  - Next state is LOAD. No SRAM write occurs for the length byte.
- LOAD:
  - in_ready=1; mem_write = in_valid (combinational); mem_addr = write pointer.
  - On handshake: SRAM[pointer] <= in_data; pointer+1 wraps 255->0 modulo 2**word_size; remaining-1.
  - The handshake that takes remaining from 1 to 0 moves to CHK if the feature is on, otherwise to RUN.
  - in_valid low stalls indefinitely with no write and no counter change.
- RUN:
  - cpu_rst_n=1, done=1, in_ready=0; stream input is ignored.
  - start -> LEN; cpu_rst_n returns to 0 on that same edge (reload).
- cpu_rst_n is a dedicated flop: 1 exactly in cycles where state==RUN, so it is glitch-free.
- start is only sampled in IDLE, RUN and ERR. start asserted in the same cycle as a LOAD handshake is ignored.
- Asynchronous rst mid-load:
  - Returns to IDLE immediately; cpu_rst_n=0.
  - Bytes already written stay in SRAM. The loader does not clear memory.
- mem_write is never high outside LOAD.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- With the macro:
  - An 8-bit running sum accumulates the length byte and every payload byte.
  - After the payload, CHK expects one further byte (in_ready=1, no SRAM write).
  - If (sum + check byte) mod 256 == 0 -> RUN; otherwise -> ERR.
  - ERR: err=1, cpu_rst_n=0, in_ready=0; start -> LEN and clears err and the sum.
- Without the macro: CHK and ERR states and the sum register are not built; err is tied 0; the last payload byte goes directly to RUN.

Decomposition:
- Shared package prog_loader_pkg holds:
  - state encoding constants (IDLE=0, LEN=1, LOAD=2, CHK=3, RUN=4, ERR=5, 3-bit);
  - the LEN_ZERO_MEANS_FULL rule constant (256).
- One sub-module, loader_counter: write pointer plus remaining counter with clear/load/decrement controls and a last-byte flag.
- The FSM and handshake stay in prog_loader.

Test Plan:
- Normal load: reset, start, send len 3 then bytes A1,B2,C3 -> SRAM[0..2]=A1,B2,C3; mem_write high exactly 3 cycles; cpu_rst_n rises on the edge after the third handshake; done=1.
- Stall: len 2, hold in_valid low 5 cycles between bytes -> no extra writes; pointer holds at 1; completion after the second byte only.
- Full image: len 0, stream 256 bytes of value address XOR 5A -> all 256 locations correct; pointer wraps to 0; RUN is entered after exactly 256 payload handshakes.
- Reset mid-load: len 4, rst low after 2 bytes -> immediate IDLE, cpu_rst_n=0, in_ready=0; SRAM[0..1] written, SRAM[2..3] untouched; a new start reloads from address 0.
- Reload from RUN: in RUN, pulse start -> cpu_rst_n=0 on the same edge; the next length byte is accepted; the new image overwrites from address 0.
- Checksum (PROG_LOADER_CHECKSUM_EN): len 2, bytes 10,20, check byte CE -> RUN. Same stream with check byte CF -> ERR, err=1, cpu_rst_n stays 0.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the SRAM program loader: state encoding and length rule.
package prog_loader_pkg;

    localparam int WORD_SIZE           = 8;
    localparam int CNT_SIZE            = 9;
    localparam int LEN_ZERO_MEANS_FULL = 256;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_LOAD = 3'd2,
        S_CHK  = 3'd3,
        S_RUN  = 3'd4,
        S_ERR  = 3'd5
    } state_e;

endpackage

// File: rtl/prog_loader_counter.sv
// Write pointer and remaining-byte counter for the program loader.
module loader_counter #(
    parameter int word_size = 8,
    parameter int cnt_size  = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 load,
    input  logic                 dec,
    input  logic [cnt_size-1:0]  load_val,
    output logic [word_size-1:0] ptr,
    output logic                 last
);

    logic [word_size-1:0] ptr_r;
    logic [cnt_size-1:0]  rem_r;

    // Pointer/remaining update; the pointer wraps naturally at 2**word_size.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r <= '0;
            rem_r <= '0;
        end else if (clr) begin
            ptr_r <= '0;
            rem_r <= '0;
        end else if (load) begin
            rem_r <= load_val;
        end else if (dec) begin
            ptr_r <= ptr_r + word_size'(1);
            rem_r <= rem_r - cnt_size'(1);
        end else begin
            ptr_r <= ptr_r;
            rem_r <= rem_r;
        end
    end

    assign ptr  = ptr_r;
    assign last = (rem_r == cnt_size'(1));

endmodule

// File: rtl/prog_loader.sv
// Streams a length-prefixed image into the 256x8 SRAM and holds the CPU in reset until done.
// Optional checksum trailer enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int word_size = 8,
    parameter int cnt_size  = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [word_size-1:0] in_data,
    output logic                 in_ready,
    output logic [word_size-1:0] mem_addr,
    output logic [word_size-1:0] mem_data,
    output logic                 mem_write,
    output logic                 cpu_rst_n,
    output logic                 done,
    output logic                 err
);

    state_e               state_r;
    state_e               next_s;
    logic                 in_ready_r;
    logic                 cpu_rst_n_r;
    logic                 done_r;
    logic                 hs_s;
    logic                 clr_s;
    logic                 load_s;
    logic                 dec_s;
    logic                 last_s;
    logic [word_size-1:0] ptr_s;
    logic [cnt_size-1:0]  load_val_s;

    assign hs_s       = in_valid & in_ready_r;
    assign load_val_s = (in_data == '0) ? cnt_size'(LEN_ZERO_MEANS_FULL) : cnt_size'(in_data);

    loader_counter #(
        .word_size (word_size),
        .cnt_size  (cnt_size)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr_s),
        .load     (load_s),
        .dec      (dec_s),
        .load_val (load_val_s),
        .ptr      (ptr_s),
        .last     (last_s)
    );

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [word_size-1:0] sum_r;
    logic [word_size-1:0] chk_sum_s;
    logic                 err_r;

    assign chk_sum_s = sum_r + in_data;

    // Running sum over the length byte and payload; cleared whenever a new load starts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_r <= '0;
        end else if (clr_s) begin
            sum_r <= '0;
        end else if (hs_s && (state_r == S_LEN || state_r == S_LOAD)) begin
            sum_r <= chk_sum_s;
        end else begin
            sum_r <= sum_r;
        end
    end
`endif

    // Next-state and counter control decode.
    always_comb begin
        next_s = state_r;
        clr_s  = 1'b0;
        load_s = 1'b0;
        dec_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    next_s = S_LEN;
                    clr_s  = 1'b1;
                end else begin
                    next_s = S_IDLE;
                end
            end
            S_LEN: begin
                if (hs_s) begin
                    load_s = 1'b1;
                    next_s = S_LOAD;
                end else begin
                    next_s = S_LEN;
                end
            end
            S_LOAD: begin
                if (hs_s) begin
                    dec_s = 1'b1;
                    if (last_s) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        next_s = S_CHK;
`else
                        next_s = S_RUN;
`endif
                    end else begin
                        next_s = S_LOAD;
                    end
                end else begin
                    next_s = S_LOAD;
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (hs_s) begin
                    if (chk_sum_s == '0) begin
                        next_s = S_RUN;
                    end else begin
                        next_s = S_ERR;
                    end
                end else begin
                    next_s = S_CHK;
                end
            end
            S_ERR: begin
                if (start) begin
                    next_s = S_LEN;
                    clr_s  = 1'b1;
                end else begin
                    next_s = S_ERR;
                end
            end
`endif
            S_RUN: begin
                if (start) begin
                    next_s = S_LEN;
                    clr_s  = 1'b1;
                end else begin
                    next_s = S_RUN;
                end
            end
            default: begin
                next_s = S_IDLE;
            end
        endcase
    end

    // State and registered outputs, all decoded from the upcoming state so they track it exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= S_IDLE;
            in_ready_r  <= 1'b0;
            cpu_rst_n_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= next_s;
            in_ready_r  <= (next_s == S_LEN) || (next_s == S_LOAD) || (next_s == S_CHK);
            cpu_rst_n_r <= (next_s == S_RUN);
            done_r      <= (next_s == S_RUN);
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    // Error flag follows the ERR state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_r <= 1'b0;
        end else begin
            err_r <= (next_s == S_ERR);
        end
    end
    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    assign in_ready  = in_ready_r;
    assign cpu_rst_n = cpu_rst_n_r;
    assign done      = done_r;
    assign mem_addr  = ptr_s;
    assign mem_data  = in_data;
    assign mem_write = in_valid & (state_r == S_LOAD);

endmodule
